uart_ahb_cmd_ctrl: RTL and testbench

Command sequencer for the UART debug master. It sits between the SoC's UART byte receiver/transmitter pair (UART_MASTER_RX/TX pins) and an AHB-Lite master port on the system bus. It parses the byte-level debug protocol: 0xA3 writes a word, 0xA5 reads a word. It then issues single-word AHB transfers, and for reads returns the data bytes to the UART transmitter. The bench uses it to poke memory-mapped registers such as the flash bit-bang window at 0x4C000000.

---
 rtl/uart_ahb_pkg.sv | 26 ++
 rtl/uart_ahb_cmd_ctrl_tmo.sv | 30 +++
 rtl/uart_ahb_cmd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_ahb_cmd_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ahb_pkg.sv
// Shared constants and state encoding for the UART-to-AHB debug command sequencer.
package uart_ahb_pkg;

  localparam logic [7:0] CMD_WR        = 8'hA3;
  localparam logic [7:0] CMD_RD        = 8'hA5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_A,
    ST_BUS_D,
    ST_TX
  } state_e;

  // Picks byte idx (0 = least significant) out of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_ahb_cmd_ctrl_tmo.sv
// Inter-byte timeout counter for partial command frames (built only with UART_AHB_TIMEOUT_EN).
module uart_ahb_tmo #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CW             = 21
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CW-1:0] Limit = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Saturates at the limit so a stuck enable cannot wrap back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == Limit);

endmodule

// File: rtl/uart_ahb_cmd_ctrl.sv
// UART debug-protocol parser driving single-word AHB-Lite transfers; reads are echoed to the UART.
// Optional inter-byte frame timeout is enabled by defining UART_AHB_TIMEOUT_EN.
module uart_ahb_cmd_ctrl
  import uart_ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CW             = 21
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        busy,
  output logic        drop,
  output logic        timeout
);

  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CW)) begin : g_bad_cfg
    $error("CW is too narrow to hold TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  logic        timeout_q, timeout_d;

  logic inFrame;
  logic tmoExpire;
  logic tmoAbort;

  assign inFrame  = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign tmoAbort = inFrame && !rx_valid && tmoExpire;

`ifdef UART_AHB_TIMEOUT_EN
  uart_ahb_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CW            (CW)
  ) u_tmo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .clr_i   (!inFrame || rx_valid),
    .en_i    (inFrame),
    .expire_o(tmoExpire)
  );
`else
  assign tmoExpire = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  // The 2-bit byte counter wraps to 0 after the 4th byte, so it is ready for the next phase.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_valid && (rx_data == CMD_WR)) begin
          wr_d    = 1'b1;
          state_d = ST_ADDR;
        end else if (rx_valid && (rx_data == CMD_RD)) begin
          wr_d    = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = wr_q ? ST_WDATA : ST_BUS_A;
        end else if (tmoAbort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (rx_valid) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_BUS_A;
        end else if (tmoAbort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_BUS_A: begin
        if (HREADY) state_d = ST_BUS_D;
      end
      ST_BUS_D: begin
        if (HREADY) begin
          if (wr_q) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = HRDATA;
            cnt_d   = '0;
            state_d = ST_TX;
          end
        end
      end
      ST_TX: begin
        if (tx_valid_q && tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    htrans_d   = (state_d == ST_BUS_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_d    = (state_d == ST_BUS_A) ? addr_d : haddr_q;
    hwrite_d   = (state_d == ST_BUS_A) ? wr_d : 1'b0;
    hwdata_d   = (state_d == ST_BUS_D) ? wdata_q : hwdata_q;
    tx_valid_d = (state_d == ST_TX);
    tx_data_d  = (state_d == ST_TX) ? byte_sel(rdata_d, cnt_d) : tx_data_q;
    busy_d     = (state_d != ST_IDLE);
    drop_d     = rx_valid && ((state_q == ST_BUS_A) || (state_q == ST_BUS_D) || (state_q == ST_TX));
    timeout_d  = tmoAbort;
  end

  assign HTRANS   = htrans_q;
  assign HADDR    = haddr_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = HSIZE_WORD;
  assign HWDATA   = hwdata_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign drop     = drop_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_ahb_cmd_ctrl.sv
// Self-checking bench for uart_ahb_cmd_ctrl: directed frames plus a randomized frame mix
// checked against a word-addressed memory model; timeout checks run when UART_AHB_TIMEOUT_EN is defined.
module tb_uart_ahb_cmd_ctrl;
  import uart_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        busy;
  logic        drop;
  logic        timeout;

  int nAsserts = 0;
  int nFails   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] pool [4];

  always #5 HCLK = ~HCLK;

  uart_ahb_cmd_ctrl #(
    .TIMEOUT_CYCLES(100),
    .CW            (21)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .busy    (busy),
    .drop    (drop),
    .timeout (timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge HCLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Frame bytes go out LSB first: command, 4 address bytes, then 4 data bytes for writes.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d);
    sendByte(wr ? CMD_WR : CMD_RD);
    checkOutput("busy_after_cmd", {31'd0, busy}, 32'd1);
    checkOutput("htrans_idle_in_frame", {30'd0, HTRANS}, 32'd0);
    for (int i = 0; i < 4; i++) sendByte(8'(a >> (8 * i)));
    if (wr) for (int i = 0; i < 4; i++) sendByte(8'(d >> (8 * i)));
  endtask

  // Acts as the AHB slave for one transfer; entered on the first cycle after the last frame byte.
  task automatic doBus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int waitA, input int waitD);
    checkOutput("htrans_nonseq", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    checkOutput("haddr", HADDR, a);
    checkOutput("hwrite", {31'd0, HWRITE}, {31'd0, wr});
    checkOutput("hsize", {29'd0, HSIZE}, 32'd2);
    for (int w = 0; w < waitA; w++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      checkOutput("htrans_held_nonseq", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    checkOutput("htrans_data_phase", {30'd0, HTRANS}, 32'd0);
    checkOutput("busy_data_phase", {31'd0, busy}, 32'd1);
    if (wr) checkOutput("hwdata", HWDATA, d);
    for (int w = 0; w < waitD; w++) begin
      HREADY = 1'b0;
      HRDATA = $urandom;
      @(negedge HCLK);
      checkOutput("htrans_dphase_wait", {30'd0, HTRANS}, 32'd0);
      checkOutput("tx_valid_dphase_wait", {31'd0, tx_valid}, 32'd0);
    end
    HREADY = 1'b1;
    HRDATA = rd;
    @(negedge HCLK);
    HRDATA = $urandom;
    if (wr) begin
      checkOutput("busy_after_write", {31'd0, busy}, 32'd0);
      checkOutput("tx_valid_after_write", {31'd0, tx_valid}, 32'd0);
    end else begin
      checkOutput("busy_before_tx", {31'd0, busy}, 32'd1);
    end
  endtask

  // Drains the 4 read bytes with random tx_ready stalls; optionally pokes a byte mid-TX.
  task automatic checkTx(input logic [31:0] word, input bit injectDrop);
    logic [7:0] expQ [$];
    for (int i = 0; i < 4; i++) expQ.push_back(8'((word >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) begin
      int stall;
      stall = $urandom_range(0, 2);
      if (injectDrop && i == 1) stall = 3;
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        checkOutput("tx_valid_stall", {31'd0, tx_valid}, 32'd1);
        checkOutput("tx_data_stall", {24'd0, tx_data}, {24'd0, expQ[i]});
        if (injectDrop && i == 1 && s == 0) begin
          rx_data  = 8'h99;
          rx_valid = 1'b1;
        end
        @(negedge HCLK);
        rx_valid = 1'b0;
        if (injectDrop && i == 1 && s == 0) checkOutput("drop_pulse", {31'd0, drop}, 32'd1);
        if (injectDrop && i == 1 && s == 1) checkOutput("drop_one_cycle", {31'd0, drop}, 32'd0);
      end
      checkOutput("tx_valid", {31'd0, tx_valid}, 32'd1);
      checkOutput("tx_data", {24'd0, tx_data}, {24'd0, expQ[i]});
      tx_ready = 1'b1;
      @(negedge HCLK);
    end
    tx_ready = 1'b0;
    checkOutput("tx_valid_done", {31'd0, tx_valid}, 32'd0);
    checkOutput("busy_after_read", {31'd0, busy}, 32'd0);
  endtask

  task automatic runFrame(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int waitA, input int waitD, input bit injectDrop);
    logic [31:0] rd;
    rd = mem.exists(a) ? mem[a] : $urandom;
    applyStimulus(wr, a, d);
    doBus(wr, a, d, rd, waitA, waitD);
    if (wr) mem[a] = d;
    else checkTx(rd, injectDrop);
  endtask

  initial begin
    HRESETn  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    HREADY   = 1'b1;
    HRDATA   = 32'h0;
    repeat (3) @(negedge HCLK);
    checkOutput("rst_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("rst_haddr", HADDR, 32'd0);
    checkOutput("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    checkOutput("rst_hwdata", HWDATA, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_drop", {31'd0, drop}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    $display("[TB] write frame to flash window");
    runFrame(1'b1, 32'h4C00_0000, 32'hA5A8_5501, 0, 0, 1'b0);

    $display("[TB] read frame with 3 data-phase wait states");
    mem[32'h4C00_0018] = 32'h1234_5678;
    runFrame(1'b0, 32'h4C00_0018, 32'h0, 0, 3, 1'b0);

    $display("[TB] junk byte in idle, then write");
    sendByte(8'h55);
    checkOutput("junk_no_drop", {31'd0, drop}, 32'd0);
    checkOutput("junk_not_busy", {31'd0, busy}, 32'd0);
    runFrame(1'b1, 32'h4C00_0004, $urandom, 0, 0, 1'b0);

    $display("[TB] byte dropped while tx stalled");
    runFrame(1'b0, 32'h4C00_0000, 32'h0, 1, 1, 1'b1);

`ifdef UART_AHB_TIMEOUT_EN
    begin
      int  n;
      bit  seen;
      $display("[TB] partial frame timeout");
      sendByte(CMD_WR);
      sendByte(8'h11);
      sendByte(8'h22);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
        @(negedge HCLK);
        n++;
        if (timeout === 1'b1) seen = 1'b1;
      end
      checkOutput("tmo_seen", {31'd0, seen}, 32'd1);
      checkOutput("tmo_cycles", n, 32'd101);
      checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
      @(negedge HCLK);
      checkOutput("tmo_one_cycle", {31'd0, timeout}, 32'd0);
      runFrame(1'b1, 32'h4C00_0008, $urandom, 0, 0, 1'b0);
    end
`endif

    $display("[TB] reset during data phase");
    applyStimulus(1'b0, 32'h4C00_0010, 32'h0);
    checkOutput("rstd_nonseq", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    checkOutput("rstd_in_bus_d", {31'd0, busy}, 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    checkOutput("rstd_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("rstd_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstd_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    @(negedge HCLK);

    $display("[TB] randomized frame mix");
    pool[0] = 32'h4C00_0000;
    pool[1] = 32'h4C00_0004;
    pool[2] = 32'h2000_0010;
    pool[3] = $urandom;
    for (int k = 0; k < 24; k++) begin
      runFrame(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom,
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
